// File: rtl/postfix_evaluator_if.sv
// postfix_evaluator_if
//   Token-in / result-out handshake bundle for the RPN evaluator.
//   master : token producer and result consumer (converter + host side)
//   slave  : the evaluator
//   Signals:
//     in_stb, in_data[31:0], in_is_operator  token offered (held until in_ack)
//     in_ack                                 one-cycle token-consumed pulse
//     result_stb, result_data[31:0],
//     result_err, err_code[2:0]              result offered (held until result_ack)
//     result_ack                             host accepted the result
interface postfix_evaluator_if;
  logic        in_stb;
  logic [31:0] in_data;
  logic        in_is_operator;
  logic        in_ack;
  logic        result_stb;
  logic [31:0] result_data;
  logic        result_err;
  logic [2:0]  err_code;
  logic        result_ack;

  modport master (
    output in_stb, in_data, in_is_operator, result_ack,
    input  in_ack, result_stb, result_data, result_err, err_code
  );

  modport slave (
    input  in_stb, in_data, in_is_operator, result_ack,
    output in_ack, result_stb, result_data, result_err, err_code
  );
endinterface

// File: rtl/postfix_evaluator.sv
// postfix_evaluator
//   Stack-based RPN evaluator. Consumes postfix tokens (operands and opcodes)
//   from the shunting-yard converter and returns one 32-bit result per
//   expression, terminated by the '=' token.
//   Opcodes: ADD=000 SUB=001 MUL=010 DIV=011 EXP=100 '='=101 '('=110 ')'=111
//   Ports:
//     CLK    rising-edge clock
//     RST    asynchronous active-high reset
//     bus    postfix_evaluator_if.slave (token in, result out)
//     depth  current number of operands on the stack
//   Error codes (first error wins): 1 underflow, 2 overflow, 3 divide by zero,
//   4 '=' with depth != 1, 5 illegal operator, 6 negative exponent.
module postfix_evaluator #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  postfix_evaluator_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_EXP    = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EXP = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;

  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_OVER  = 3'd2;
  localparam logic [2:0] ERR_DIV0  = 3'd3;
  localparam logic [2:0] ERR_DEPTH = 3'd4;
  localparam logic [2:0] ERR_ILLOP = 3'd5;
  localparam logic [2:0] ERR_NEGEX = 3'd6;

  // Wrapping two's-complement ALU. The most-negative / -1 quotient is
  // forced to the wrapped negation so the divider never has an undefined case.
  function automatic logic signed [WIDTH-1:0] alu(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: begin
        if (b == '0)
          r = '0;
        else if (b == {WIDTH{1'b1}})
          r = '0 - a;
        else
          r = a / b;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Sticky error: only the first error of an expression is recorded.
  function automatic logic [2:0] first_err(input logic [2:0] cur, input logic [2:0] nxt);
    return (cur != 3'd0) ? cur : nxt;
  endfunction

  // Control state
  logic [2:0]              state;
  logic                    skip;
  logic [SP_W-1:0]         sp;
  logic [2:0]              err_code_q;
  logic                    result_stb_q;
  logic                    result_err_q;
  logic signed [WIDTH-1:0] result_data_q;

  // Datapath state (never reset)
  logic signed [WIDTH-1:0] stack [0:(1<<IDX_W)-1];
  logic signed [WIDTH-1:0] acc;
  logic [WIDTH-1:0]        cnt;
  logic [2:0]              op_q;

  logic                    take;
  logic                    is_op;
  logic [2:0]              opc;
  logic                    is_eq;
  logic                    err_pend;
  logic                    sp_full;
  logic                    sp_lt2;
  logic [IDX_W-1:0]        top_idx;
  logic [IDX_W-1:0]        sec_idx;
  logic signed [WIDTH-1:0] a_val;
  logic signed [WIDTH-1:0] b_val;
  logic signed [WIDTH-1:0] tok_val;
  logic                    div_zero;

  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic signed [WIDTH-1:0] wr_val;

  assign is_op    = bus.in_is_operator;
  assign opc      = bus.in_data[2:0];
  assign tok_val  = bus.in_data;
  assign is_eq    = is_op && (opc == OP_EQ);
  assign err_pend = (err_code_q != 3'd0);
  assign sp_full  = (sp == SP_W'(DEPTH));
  assign sp_lt2   = (sp < SP_W'(2));
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign sec_idx  = IDX_W'(sp - SP_W'(2));
  assign a_val    = stack[sec_idx];
  assign b_val    = stack[top_idx];
  assign div_zero = (op_q == OP_DIV) && (b_val == '0);

  // The cycle after an ACK is never sampled: the converter still holds
  // in_stb for that cycle before dropping it.
  assign take = bus.in_stb && !skip && ((state == ST_IDLE) || (state == ST_DRAIN));

  assign bus.in_ack      = (state == ST_ACK);
  assign bus.result_stb  = result_stb_q;
  assign bus.result_data = result_data_q;
  assign bus.result_err  = result_err_q;
  assign bus.err_code    = err_code_q;
  assign depth           = sp;

  // Single stack write port: push, binary-op result, or exponent result.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if ((state == ST_IDLE) && take && !is_op && !sp_full) begin
      wr_en  = 1'b1;
      wr_idx = IDX_W'(sp);
      wr_val = tok_val;
    end else if ((state == ST_EXEC) && !sp_lt2 && !div_zero) begin
      wr_en  = 1'b1;
      wr_idx = sec_idx;
      wr_val = alu(op_q, a_val, b_val);
    end else if ((state == ST_EXP) && (cnt == '0)) begin
      wr_en  = 1'b1;
      wr_idx = sec_idx;
      wr_val = acc;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      stack[wr_idx] <= wr_val;

    // EXP: acc starts at 1 with cnt = b, then multiplies by a once per cycle.
    if ((state == ST_IDLE) && take && is_op && (opc == OP_EXP)) begin
      acc <= WIDTH'(1);
      cnt <= $unsigned(b_val);
    end else if ((state == ST_EXP) && (cnt != '0)) begin
      acc <= acc * a_val;
      cnt <= cnt - WIDTH'(1);
    end

    if ((state == ST_IDLE) && take && is_op)
      op_q <= opc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= ST_IDLE;
      skip          <= 1'b0;
      sp            <= '0;
      err_code_q    <= 3'd0;
      result_stb_q  <= 1'b0;
      result_err_q  <= 1'b0;
      result_data_q <= '0;
    end else begin
      skip <= (state == ST_ACK);
      case (state)
        ST_IDLE, ST_DRAIN: begin
          if (take) begin
            if (is_eq) begin
              // '=' is not acked here; the ack follows result_ack.
              result_stb_q <= 1'b1;
              if (!err_pend && (sp == SP_W'(1))) begin
                result_data_q <= b_val;
                result_err_q  <= 1'b0;
              end else begin
                result_data_q <= '0;
                result_err_q  <= 1'b1;
                err_code_q    <= first_err(err_code_q, ERR_DEPTH);
              end
              state <= ST_RESULT;
            end else if (state == ST_DRAIN) begin
              state <= ST_ACK;
            end else if (!is_op) begin
              if (sp_full)
                err_code_q <= first_err(err_code_q, ERR_OVER);
              else
                sp <= sp + SP_W'(1);
              state <= ST_ACK;
            end else begin
              case (opc)
                OP_ADD, OP_SUB, OP_MUL, OP_DIV: state <= ST_EXEC;
                OP_EXP: begin
                  if (sp_lt2) begin
                    err_code_q <= first_err(err_code_q, ERR_UNDER);
                    state      <= ST_ACK;
                  end else if (b_val < 0) begin
                    err_code_q <= first_err(err_code_q, ERR_NEGEX);
                    state      <= ST_ACK;
                  end else begin
                    state <= ST_EXP;
                  end
                end
                default: begin
                  err_code_q <= first_err(err_code_q, ERR_ILLOP);
                  state      <= ST_ACK;
                end
              endcase
            end
          end
        end

        ST_EXEC: begin
          if (sp_lt2)
            err_code_q <= first_err(err_code_q, ERR_UNDER);
          else if (div_zero)
            err_code_q <= first_err(err_code_q, ERR_DIV0);
          else
            sp <= sp - SP_W'(1);
          state <= ST_ACK;
        end

        ST_EXP: begin
          if (cnt == '0) begin
            sp    <= sp - SP_W'(1);
            state <= ST_ACK;
          end
        end

        ST_ACK: state <= err_pend ? ST_DRAIN : ST_IDLE;

        ST_RESULT: begin
          if (bus.result_ack) begin
            result_stb_q <= 1'b0;
            result_err_q <= 1'b0;
            err_code_q   <= 3'd0;
            sp           <= '0;
            state        <= ST_ACK;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
module tb_postfix_evaluator;

  localparam int DEPTH     = 16;
  localparam int ACK_LIMIT = 100;

  typedef struct packed {
    logic        op;
    logic [31:0] val;
  } tok_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] depth;

  postfix_evaluator_if bus();

  postfix_evaluator #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus),
    .depth (depth)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ack_cnt = 0;
  int dbl_cnt = 0;
  logic prev_ack = 1'b0;

  tok_t expr[$];
  int   exp_lat[$];
  int   exp_res;
  int   exp_code;
  bit   exp_err;

  always @(negedge clk) begin
    if (bus.in_ack) begin
      ack_cnt <= ack_cnt + 1;
      if (prev_ack) dbl_cnt <= dbl_cnt + 1;
    end
    prev_ack <= bus.in_ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, obs, obs, expv, expv);
  endtask

  task automatic push_num(input int v);
    tok_t t;
    t.op = 1'b0; t.val = v;
    expr.push_back(t);
  endtask

  task automatic push_op(input int c);
    tok_t t;
    t.op = 1'b1; t.val = c;
    expr.push_back(t);
  endtask

  // Behavioural reference: evaluate the token list with an int queue.
  task automatic model_eval();
    int st[$];
    int a, b, r, code, lat;
    tok_t t;
    code = 0;
    exp_lat.delete();
    foreach (expr[i]) begin
      t = expr[i];
      lat = -1;
      if (t.op && t.val[2:0] == 3'd5) begin
        if (code == 0 && st.size() != 1) code = 4;
        exp_lat.push_back(-1);
        break;
      end
      if (code != 0) begin
        lat = 2;
      end else if (!t.op) begin
        if (st.size() >= DEPTH) code = 2;
        else st.push_back(int'(t.val));
        lat = 2;
      end else begin
        case (t.val[2:0])
          3'd0, 3'd1, 3'd2, 3'd3: begin
            lat = 3;
            if (st.size() < 2) code = 1;
            else begin
              b = st.pop_back();
              a = st.pop_back();
              if (t.val[2:0] == 3'd3 && b == 0) code = 3;
              else begin
                case (t.val[2:0])
                  3'd0: r = a + b;
                  3'd1: r = a - b;
                  3'd2: r = a * b;
                  default: r = (b == -1) ? -a : a / b;
                endcase
                st.push_back(r);
              end
            end
          end
          3'd4: begin
            if (st.size() < 2) code = 1;
            else if (st[st.size()-1] < 0) code = 6;
            else begin
              b = st.pop_back();
              a = st.pop_back();
              r = 1;
              for (int k = 0; k < b; k++) r = r * a;
              st.push_back(r);
              lat = b + 3;
            end
          end
          default: begin
            code = 5;
            lat = 2;
          end
        endcase
      end
      exp_lat.push_back(lat);
    end
    exp_code = code;
    exp_err  = (code != 0);
    exp_res  = (code != 0) ? 0 : st[0];
  endtask

  // Count negedges from the drive point until in_ack; -1 on timeout.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.in_ack && lat < ACK_LIMIT);
    if (!bus.in_ack) lat = -1;
  endtask

  task automatic send_tok(input tok_t t, output int lat);
    bus.in_stb = 1'b1;
    bus.in_data = t.val;
    bus.in_is_operator = t.op;
    wait_ack(lat);
    @(posedge clk); #1;
    bus.in_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_expr(input string name, input int hold);
    int lat, acks0, w;
    logic [31:0] rd;
    logic re;
    logic [2:0] rc;
    bit stable;
    model_eval();
    acks0 = ack_cnt;
    foreach (expr[i]) begin
      if (expr[i].op && expr[i].val[2:0] == 3'd5) begin
        bus.in_stb = 1'b1;
        bus.in_data = expr[i].val;
        bus.in_is_operator = 1'b1;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.result_stb && w < ACK_LIMIT);
        chk({name, "_stb"}, 32'(bus.result_stb), 32'd1);
        chk({name, "_data"}, bus.result_data, exp_res);
        chk({name, "_err"}, 32'(bus.result_err), 32'(exp_err));
        chk({name, "_code"}, 32'(bus.err_code), exp_code);
        if (exp_code == 0) chk({name, "_depth1"}, 32'(depth), 32'd1);
        rd = bus.result_data; re = bus.result_err; rc = bus.err_code;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (bus.result_stb !== 1'b1 || bus.result_data !== rd || bus.result_err !== re ||
              bus.err_code !== rc || bus.in_ack !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({name, "_hold"}, 32'(stable), 32'd1);
        @(posedge clk); #1;
        bus.result_ack = 1'b1;
        wait_ack(lat);
        chk({name, "_eq_ack"}, 32'(lat > 0), 32'd1);
        @(posedge clk); #1;
        bus.in_stb = 1'b0;
        bus.result_ack = 1'b0;
        @(negedge clk);
        chk({name, "_stb_clr"}, 32'(bus.result_stb), 32'd0);
        chk({name, "_depth0"}, 32'(depth), 32'd0);
        chk({name, "_code_clr"}, 32'(bus.err_code), 32'd0);
        @(posedge clk); #1;
      end else begin
        send_tok(expr[i], lat);
        if (exp_lat[i] >= 0) chk($sformatf("%s_lat%0d", name, i), lat, exp_lat[i]);
        else chk($sformatf("%s_ack%0d", name, i), 32'(lat > 0), 32'd1);
      end
    end
    chk({name, "_acks"}, ack_cnt - acks0, expr.size());
  endtask

  task automatic gen_expr();
    int cnt, n, r, v;
    bit last_small;
    expr.delete();
    cnt = 0;
    last_small = 1'b0;
    n = $urandom_range(1, 10);
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        push_op($urandom_range(6, 7));
        last_small = 1'b0;
      end else if (r < 8) begin
        push_op($urandom_range(0, 3));
        if (cnt >= 2) cnt--;
        last_small = 1'b0;
      end else if (cnt >= 2 && last_small && r < 30) begin
        push_op(4);
        cnt--;
        last_small = 1'b0;
      end else if (cnt >= 2 && r < 55) begin
        push_op($urandom_range(0, 3));
        cnt--;
        last_small = 1'b0;
      end else begin
        v = (r < 92) ? $urandom_range(0, 16) - 8 : $urandom;
        push_num(v);
        cnt++;
        last_small = (v >= 0 && v <= 5);
      end
    end
    if ($urandom_range(0, 9) < 8)
      while (cnt > 1) begin
        push_op($urandom_range(0, 2));
        cnt--;
      end
    push_op(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acks0;
    tok_t t;
    bus.in_stb = 1'b0;
    bus.in_data = '0;
    bus.in_is_operator = 1'b0;
    bus.result_ack = 1'b0;
    rst = 1'b1;
    #7;
    chk("rst_in_ack", 32'(bus.in_ack), 32'd0);
    chk("rst_stb", 32'(bus.result_stb), 32'd0);
    chk("rst_data", bus.result_data, 32'd0);
    chk("rst_err", 32'(bus.result_err), 32'd0);
    chk("rst_code", 32'(bus.err_code), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    expr.delete(); push_num(3); push_num(4); push_op(0); push_num(2); push_op(2); push_op(5);
    run_expr("add_mul", 0);
    expr.delete(); push_num(2); push_num(3); push_num(2); push_op(4); push_op(4); push_op(5);
    run_expr("exp_chain", 0);
    expr.delete(); push_num(-7); push_num(2); push_op(3); push_op(5);
    run_expr("div_neg", 0);
    expr.delete(); push_num(7); push_num(0); push_op(3); push_num(5); push_op(0); push_op(5);
    run_expr("div0", 0);
    expr.delete(); push_op(0); push_op(5);
    run_expr("underflow", 0);
    expr.delete(); push_num(1); push_num(2); push_op(5);
    run_expr("depth_ne1", 0);
    expr.delete();
    for (int k = 0; k <= DEPTH; k++) push_num(k + 1);
    push_op(5);
    run_expr("overflow", 0);
    expr.delete(); push_num(2); push_num(-1); push_op(4); push_op(5);
    run_expr("neg_exp", 0);
    expr.delete(); push_num(1); push_op(6); push_num(4); push_op(5);
    run_expr("paren", 0);
    expr.delete(); push_num(5); push_num(0); push_op(4); push_op(5);
    run_expr("exp_zero", 0);
    expr.delete(); push_num(6); push_num(7); push_op(2); push_op(5);
    run_expr("hold", 10);
    expr.delete(); push_num(5); push_num(5); push_op(1); push_op(5);
    run_expr("after_hold", 0);

    // Reset in the middle of a long exponentiation.
    t.op = 1'b0; t.val = 32'd3;
    send_tok(t, lat);
    t.val = 32'd20;
    send_tok(t, lat);
    acks0 = ack_cnt;
    bus.in_stb = 1'b1;
    bus.in_data = 32'd4;
    bus.in_is_operator = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ack", 32'(bus.in_ack), 32'd0);
    chk("mid_rst_stb", 32'(bus.result_stb), 32'd0);
    chk("mid_rst_data", bus.result_data, 32'd0);
    chk("mid_rst_err", 32'(bus.result_err), 32'd0);
    chk("mid_rst_code", 32'(bus.err_code), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    @(posedge clk); #1;
    bus.in_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_ack", ack_cnt - acks0, 32'd0);
    @(posedge clk); #1;
    expr.delete(); push_num(1); push_num(1); push_op(0); push_op(5);
    run_expr("post_rst", 0);

    for (int r = 0; r < 40; r++) begin
      gen_expr();
      run_expr($sformatf("rnd%0d", r), (r % 7 == 0) ? 3 : 0);
    end

    chk("ack_double", dbl_cnt, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/postfix_evaluator.md
Name: postfix_evaluator

Overview:
Stack-based RPN evaluator that consumes the postfix token stream produced by the shunting-yard converter and returns one 32-bit result per expression. It sits directly downstream of the converter. Its token input is the converter's output_stb / output_data / is_output_operator / output_ack handshake, and its result output goes to the host/testbench. Opcodes are shared with the converter and SIMD ALU: ADD=000, SUB=001, MUL=010, DIV=011, EXP=100, '='=101, '('=110, ')'=111.

Parameters:
DEPTH, 16, operand stack entries (≥2)
WIDTH, 32, operand/result width (fixed 32 in this revision)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
in_stb  input  1  token valid; held by converter until in_ack
in_data  input  32  operand value, or opcode in [2:0] when in_is_operator=1
in_is_operator  input  1  1 = in_data[2:0] is opcode
in_ack  output  1  one-cycle pulse: token consumed
result_stb  output  1  result valid, held until result_ack
result_data  output  32  evaluated value (0 when result_err=1)
result_err  output  1  expression failed
err_code  output  3  first error: 0 none, 1 underflow, 2 overflow, 3 div-by-zero, 4 '=' with depth≠1, 5 illegal op (paren/unknown), 6 negative exponent
result_ack  input  1  host accepted result
depth  output  $clog2(DEPTH+1)  current operand count

Behaviour:
- Reset (async) and initial: in_ack=0, result_stb=0, result_data=0, result_err=0, err_code=0, depth=0, FSM=IDLE, sticky error cleared. Reset mid-operation (incl. mid-EXP) abandons everything; no ack or result is produced afterwards.
- Arithmetic: two's-complement signed, wrap modulo 2^32. MUL keeps the low 32 bits. DIV truncates toward zero. Operand order: a = second-from-top, b = top; result = a op b; pops 2, pushes 1.
- FSM states: IDLE, EXEC, EXP, ACK, RESULT, DRAIN.
- IDLE: sample in_stb=1.
  - Number: push (overflow if depth==DEPTH) → ACK.
  - ADD/SUB/MUL/DIV → EXEC.
  - EXP → EXP, initialised with acc=1, cnt=b.
  - '=' → RESULT.
  - 110/111 → err 5, then ACK.
- EXEC (1 cycle):
  - depth<2 → err 1.
  - DIV with b==0 → err 3.
  - Otherwise write result at slot depth-2 and decrement depth.
  - → ACK.
- EXP:
  - Entry checks: depth<2 → err 1; b<0 → err 6.
  - Each cycle acc=acc*a (low 32 bits) and cnt--. When cnt==0, write acc and decrement depth.
  - b==0 yields 1.
  - Latency is b+1 cycles; in_ack stays low throughout.
  - → ACK.
- ACK: in_ack=1 for exactly this cycle.
  - The next cycle is not sampled for in_stb, because the converter drops stb one cycle after seeing ack.
  - → IDLE, or DRAIN if an error is pending.
- Token latency: number = 2 cycles from sample to in_ack; ADD..DIV = 3 cycles; EXP = b+3 cycles.
- RESULT:
  - If no error and depth==1, result_data=top. If no error and depth≠1, raise err 4.
  - Assert result_stb and hold result_data, result_err, err_code stable until result_ack.
  - On result_ack: result_stb=0, depth=0, errors cleared, in_ack pulse for the '=' token, then IDLE.
  - The '=' token is acknowledged only after result_ack, which backpressures the converter.
- Errors:
  - The first error latches err_code; later errors do not overwrite it.
  - After an error the FSM enters DRAIN: every token is acked (same ACK timing) without touching the stack until '='. Then RESULT with result_err=1 and result_data=0.
- Boundaries:
  - Push at depth==DEPTH: the token is not stored, err 2.
  - Stack pointer never wraps; depth saturates within 0..DEPTH.
  - result_ack while result_stb=0 is ignored.
  - in_stb held during EXEC/EXP/RESULT is not re-sampled.

Test Plan:
- Tokens 3,4,ADD,2,MUL,'=' (converter output of "(3+4)*2=") → result_data=14, err=0, depth 0 after ack.
- 2,3,2,EXP,EXP,'=' → 512; the second EXP's in_ack arrives ≥3 cycles after sample; in_ack never high two consecutive cycles.
- -7,2,DIV,'=' → 0xFFFFFFFD; 7,0,DIV,5,ADD,'=' → result_err=1, err_code=3, result_data=0, all 6 tokens acked.
- ADD,'=' → err_code=1; 1,2,'=' → err_code=4; DEPTH+1 numbers then '=' → err_code=2.
- Hold result_ack low 10 cycles after result_stb → outputs stable and '=' not acked; then ack → next expression 5,5,SUB,'=' returns 0.
- Assert RST during EXP of 3,20,EXP → all outputs at reset values immediately; then 1,1,ADD,'=' → 2.
